// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/stall/flush control for the 5-stage core
//
// Resolves load-use hazards (decode vs execute), execute mispredicts and
// multi-cycle data-memory waits.  A mispredict seen while memory is stalled
// is parked in r_pend_valid/r_pend_pc and applied on the release cycle.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   decode_i_rs1/rs2(_used)           decode source registers and use flags
//   regE_i_is_load/wb_reg_wen/wb_rd   execute-stage destination info
//   execute_i_mispredict/redirect_pc  branch resolution from execute
//   mem_i_req/mem_i_ready             memory-stage access handshake
//   ctrl_o_reg{F,D,E,M}_stall         hold stage registers
//   ctrl_o_reg{D,E,W}_bubble          load NOP into stage registers
//   ctrl_o_redirect_valid/_pc         fetch redirect
//   ctrl_o_busy                       FSM is in MEM_WAIT
//   ctrl_o_stall_cnt/flush_cnt        perf counters
//
// Optional feature macro: PIPE_CTRL_PERF_EN (builds the perf counters;
// without it both counter outputs are constant 0).
module pipe_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      decode_i_rs1,
    input  logic [4:0]      decode_i_rs2,
    input  logic            decode_i_rs1_used,
    input  logic            decode_i_rs2_used,
    input  logic            regE_i_is_load,
    input  logic            regE_i_wb_reg_wen,
    input  logic [4:0]      regE_i_wb_rd,
    input  logic            execute_i_mispredict,
    input  logic [XLEN-1:0] execute_i_redirect_pc,
    input  logic            mem_i_req,
    input  logic            mem_i_ready,
    output logic            ctrl_o_regF_stall,
    output logic            ctrl_o_regD_stall,
    output logic            ctrl_o_regE_stall,
    output logic            ctrl_o_regM_stall,
    output logic            ctrl_o_regD_bubble,
    output logic            ctrl_o_regE_bubble,
    output logic            ctrl_o_regW_bubble,
    output logic            ctrl_o_redirect_valid,
    output logic [XLEN-1:0] ctrl_o_redirect_pc,
    output logic            ctrl_o_busy,
    output logic [XLEN-1:0] ctrl_o_stall_cnt,
    output logic [XLEN-1:0] ctrl_o_flush_cnt
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t          r_state;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_pc;

    logic w_memstall;
    logic w_loaduse;
    logic w_flush;

    assign w_memstall = mem_i_req && !mem_i_ready;
    assign w_loaduse  = regE_i_is_load && regE_i_wb_reg_wen && (regE_i_wb_rd != 5'd0) &&
                        ((decode_i_rs1_used && decode_i_rs1 == regE_i_wb_rd) ||
                         (decode_i_rs2_used && decode_i_rs2 == regE_i_wb_rd));
    assign w_flush    = !w_memstall && (execute_i_mispredict || r_pend_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
            ctrl_o_busy  <= 1'b0;
        end else begin
            r_state     <= w_memstall ? MEM_WAIT : RUN;
            ctrl_o_busy <= w_memstall;
            // Only the first mispredict of a wait is kept; it is the oldest.
            if (w_memstall && execute_i_mispredict && !r_pend_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_pc    <= execute_i_redirect_pc;
            end else if (w_flush) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Outputs are gated by rst_n so they show reset values while it is low.
    always_comb begin
        ctrl_o_regF_stall     = rst_n && (w_memstall || (!w_flush && w_loaduse));
        ctrl_o_regD_stall     = ctrl_o_regF_stall;
        ctrl_o_regE_stall     = rst_n && w_memstall;
        ctrl_o_regM_stall     = rst_n && w_memstall;
        ctrl_o_regD_bubble    = !rst_n || w_flush;
        ctrl_o_regE_bubble    = !rst_n || (!w_memstall && (w_flush || w_loaduse));
        ctrl_o_regW_bubble    = !rst_n || w_memstall;
        ctrl_o_redirect_valid = rst_n && w_flush;
        ctrl_o_redirect_pc    = !ctrl_o_redirect_valid ? '0 :
                                r_pend_valid ? r_pend_pc : execute_i_redirect_pc;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [XLEN-1:0] r_stall_cnt;
    logic [XLEN-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + XLEN'(ctrl_o_regF_stall);
            r_flush_cnt <= r_flush_cnt + XLEN'(ctrl_o_redirect_valid);
        end
    end

    assign ctrl_o_stall_cnt = r_stall_cnt;
    assign ctrl_o_flush_cnt = r_flush_cnt;
`else
    assign ctrl_o_stall_cnt = '0;
    assign ctrl_o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [4:0]      rs1, rs2, rd;
    logic            rs1_used, rs2_used, is_load, wen, mispredict, req, ready;
    logic [XLEN-1:0] rpc;
    logic            f_st, d_st, e_st, m_st, d_bb, e_bb, w_bb, rv, busy;
    logic [XLEN-1:0] opc, scnt, fcnt;
    logic [7:0]      ctl;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // {F,D,E,M stall, D,E,W bubble, redirect_valid}
    assign ctl = {f_st, d_st, e_st, m_st, d_bb, e_bb, w_bb, rv};

    localparam logic [7:0] IDLE  = 8'b0000_0000;
    localparam logic [7:0] LU    = 8'b1100_0100;
    localparam logic [7:0] MEMST = 8'b1111_0010;
    localparam logic [7:0] FLUSH = 8'b0000_1101;
    localparam logic [7:0] RST   = 8'b0000_1110;

    pipe_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .decode_i_rs1(rs1), .decode_i_rs2(rs2),
        .decode_i_rs1_used(rs1_used), .decode_i_rs2_used(rs2_used),
        .regE_i_is_load(is_load), .regE_i_wb_reg_wen(wen), .regE_i_wb_rd(rd),
        .execute_i_mispredict(mispredict), .execute_i_redirect_pc(rpc),
        .mem_i_req(req), .mem_i_ready(ready),
        .ctrl_o_regF_stall(f_st), .ctrl_o_regD_stall(d_st),
        .ctrl_o_regE_stall(e_st), .ctrl_o_regM_stall(m_st),
        .ctrl_o_regD_bubble(d_bb), .ctrl_o_regE_bubble(e_bb), .ctrl_o_regW_bubble(w_bb),
        .ctrl_o_redirect_valid(rv), .ctrl_o_redirect_pc(opc),
        .ctrl_o_busy(busy), .ctrl_o_stall_cnt(scnt), .ctrl_o_flush_cnt(fcnt)
    );

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0;
        is_load = 0; wen = 0; mispredict = 0; rpc = '0; req = 0; ready = 0;
    endtask

    // advance to 1 time unit after the next rising edge; inputs are driven here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        req = 1; mispredict = 1; rpc = 32'hdead_beef;
        #2;
        total++; if (ctl !== RST) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, RST); end
        total++; if (opc !== '0) begin bad++; $display("FAIL reset_pc got=%h exp=0", opc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (scnt !== '0 || fcnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", scnt, fcnt); end
        step();
        idle();
        rst_n = 1;
        #1;
        total++; if (ctl !== IDLE) begin bad++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, IDLE); end
    endtask

    task automatic test_memwait();
        step();
        req = 1; ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (ctl !== MEMST) begin bad++; $display("FAIL memwait_ctl c%0d got=%b exp=%b", c, ctl, MEMST); end
            total++; if (busy !== (c != 0)) begin bad++; $display("FAIL memwait_busy c%0d got=%b exp=%b", c, busy, c != 0); end
            step();
        end
        ready = 1;
        #1;
        total++; if (ctl !== IDLE) begin bad++; $display("FAIL mem_release_ctl got=%b exp=%b", ctl, IDLE); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mem_release_busy got=%b exp=1", busy); end
        step();
        idle();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mem_after_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mispredict();
        step();
        mispredict = 1; rpc = 32'h8000_0040;
        #1;
        total++; if (ctl !== FLUSH) begin bad++; $display("FAIL mispredict_ctl got=%b exp=%b", ctl, FLUSH); end
        total++; if (opc !== 32'h8000_0040) begin bad++; $display("FAIL mispredict_pc got=%h exp=80000040", opc); end
        step();
        idle();
        #1;
        total++; if (ctl !== IDLE) begin bad++; $display("FAIL mispredict_after got=%b exp=%b", ctl, IDLE); end
    endtask

    task automatic test_perf();
        step();
`ifdef PIPE_CTRL_PERF_EN
        total++; if (scnt !== 32'd3 || fcnt !== 32'd1) begin bad++; $display("FAIL perf_cnt got=%0d/%0d exp=3/1", scnt, fcnt); end
`else
        total++; if (scnt !== '0 || fcnt !== '0) begin bad++; $display("FAIL perf_cnt got=%0d/%0d exp=0/0", scnt, fcnt); end
`endif
    endtask

    task automatic test_loaduse();
        step();
        is_load = 1; wen = 1; rd = 5; rs1 = 5; rs1_used = 1;
        #1;
        total++; if (ctl !== LU) begin bad++; $display("FAIL loaduse_rs1 got=%b exp=%b", ctl, LU); end
        step();
        idle();
        rs1 = 5; rs1_used = 1;
        #1;
        total++; if (ctl !== IDLE) begin bad++; $display("FAIL loaduse_after got=%b exp=%b", ctl, IDLE); end
        step();
        is_load = 1; wen = 1; rd = 0; rs1 = 0; rs1_used = 1;
        #1;
        total++; if (ctl !== IDLE) begin bad++; $display("FAIL loaduse_x0 got=%b exp=%b", ctl, IDLE); end
        step();
        rd = 7; rs1 = 7; rs1_used = 0; rs2 = 7; rs2_used = 1;
        #1;
        total++; if (ctl !== LU) begin bad++; $display("FAIL loaduse_rs2 got=%b exp=%b", ctl, LU); end
        step();
        rs2_used = 0;
        #1;
        total++; if (ctl !== IDLE) begin bad++; $display("FAIL loaduse_unused got=%b exp=%b", ctl, IDLE); end
        step();
        wen = 0; rs1_used = 1;
        #1;
        total++; if (ctl !== IDLE) begin bad++; $display("FAIL loaduse_nowen got=%b exp=%b", ctl, IDLE); end
        step();
        idle();
    endtask

    task automatic test_pending();
        step();
        req = 1; ready = 0; mispredict = 1; rpc = 32'h100;
        #1;
        total++; if (ctl !== MEMST) begin bad++; $display("FAIL pend_w1_ctl got=%b exp=%b", ctl, MEMST); end
        step();
        rpc = 32'h200;
        #1;
        total++; if (ctl !== MEMST) begin bad++; $display("FAIL pend_w2_ctl got=%b exp=%b", ctl, MEMST); end
        step();
        mispredict = 0; rpc = 32'h0; ready = 1;
        #1;
        total++; if (ctl !== FLUSH) begin bad++; $display("FAIL pend_release_ctl got=%b exp=%b", ctl, FLUSH); end
        total++; if (opc !== 32'h100) begin bad++; $display("FAIL pend_release_pc got=%h exp=100", opc); end
        step();
        idle();
        #1;
        total++; if (ctl !== IDLE) begin bad++; $display("FAIL pend_cleared got=%b exp=%b", ctl, IDLE); end
    endtask

    task automatic test_back_to_back();
        step();
        is_load = 1; wen = 1; rd = 9; rs1 = 9; rs1_used = 1;
        mispredict = 1; rpc = 32'h0000_1234;
        #1;
        total++; if (ctl !== FLUSH) begin bad++; $display("FAIL lu_flush_ctl got=%b exp=%b", ctl, FLUSH); end
        total++; if (opc !== 32'h1234) begin bad++; $display("FAIL lu_flush_pc got=%h exp=1234", opc); end
        step();
        idle();
    endtask

    task automatic test_reset_mid_wait();
        step();
        req = 1; ready = 0; mispredict = 1; rpc = 32'h300;
        step();
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstwait_busy got=%b exp=1", busy); end
        step();
        rst_n = 0;
        #1;
        total++; if (ctl !== RST) begin bad++; $display("FAIL rstwait_ctl got=%b exp=%b", ctl, RST); end
        total++; if (busy !== 1'b0 || opc !== '0) begin bad++; $display("FAIL rstwait_busy_pc got=%b/%h exp=0/0", busy, opc); end
        total++; if (scnt !== '0 || fcnt !== '0) begin bad++; $display("FAIL rstwait_cnt got=%0d/%0d exp=0/0", scnt, fcnt); end
        step();
        idle();
        rst_n = 1;
        #1;
        total++; if (ctl !== IDLE) begin bad++; $display("FAIL rstwait_discard got=%b exp=%b", ctl, IDLE); end
        step();
        #1;
        total++; if (ctl !== IDLE) begin bad++; $display("FAIL rstwait_discard2 got=%b exp=%b", ctl, IDLE); end
    endtask

    initial begin
        test_reset();
        test_memwait();
        test_mispredict();
        test_perf();
        test_loaduse();
        test_pending();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
